expr_ci_ctrl: RTL

Multi-cycle Nios II custom-instruction controller that sequences the pipelined floating-point `expr` datapath. It accepts a start pulse and operand from the CPU and drives a stable `x` into `expr`. It waits out the datapath's fixed pipeline latency, captures `result`, and signals `done`. It also answers two bookkeeping opcodes (last result, evaluation count) without touching the datapath. It sits between the Nios II custom-instruction port and one `expr` instance inside the top-level `expr_ci` wrapper.

---
 rtl/expr_pkg.sv | 17 +
 rtl/expr_ci_ctrl.sv | 107 ++++++++++
 2 files changed

// File: rtl/expr_pkg.sv
// Shared constants for the expr custom-instruction slice: opcodes, controller states and the
// default datapath latency.
package expr_pkg;

    localparam int unsigned EXPR_LATENCY = 20;

    localparam logic [1:0] OP_EVAL  = 2'd0;
    localparam logic [1:0] OP_LAST  = 2'd1;
    localparam logic [1:0] OP_COUNT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/expr_ci_ctrl.sv
// Nios II multi-cycle custom-instruction controller for the pipelined expr datapath: holds the
// operand stable, waits out the pipeline, captures the result and pulses done.
module expr_ci_ctrl
    import expr_pkg::*;
#(
    parameter int unsigned LATENCY = EXPR_LATENCY,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [1:0]  n,
    input  logic [31:0] dataa,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] ex_x,
    input  logic [31:0] ex_result
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        ex_x_q, ex_x_d;
    logic [31:0]        result_q, result_d;
    logic [31:0]        last_q, last_d;
    logic [31:0]        eval_count_q, eval_count_d;
    logic               done_q, done_d;

    // clk_en gates every register, which also makes start count only on enabled edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ex_x_q       <= '0;
            result_q     <= '0;
            last_q       <= '0;
            eval_count_q <= '0;
            done_q       <= 1'b0;
        end else if (clk_en) begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ex_x_q       <= ex_x_d;
            result_q     <= result_d;
            last_q       <= last_d;
            eval_count_q <= eval_count_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ex_x_d       = ex_x_q;
        result_d     = result_q;
        last_d       = last_q;
        eval_count_d = eval_count_q;
        // done is the registered image of FIN, so it is high in the cycle after FIN.
        done_d       = (state_q == ST_FIN);

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (n)
                        OP_EVAL: begin
                            ex_x_d  = dataa;
                            cnt_d   = CNT_W'(LATENCY);
                            state_d = ST_BUSY;
                        end
                        OP_LAST: begin
                            result_d = last_q;
                            state_d  = ST_FIN;
                        end
                        OP_COUNT: begin
                            result_d = eval_count_q;
                            state_d  = ST_FIN;
                        end
                        default: begin
                            result_d = '0;
                            state_d  = ST_FIN;
                        end
                    endcase
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    result_d     = ex_result;
                    last_d       = ex_result;
                    eval_count_d = eval_count_q + 32'd1;
                    state_d      = ST_FIN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign done   = done_q;
    assign result = result_q;
    assign ex_x   = ex_x_q;

endmodule
